// File: rtl/pi_dac_pkg.sv
// Shared types and frame-building helpers for the VCXO tuning DAC SPI driver.
// The DAC takes a 24-bit frame: 6 don't-care bits, 2 power-down bits, 16-bit offset-binary code.
package pi_dac_pkg;

    localparam int unsigned c_frame_bits = 24;
    localparam int unsigned c_data_bits  = 16;
    localparam logic [1:0]  c_pd_normal  = 2'b00;
    localparam logic [4:0]  c_last_bit   = 5'(c_frame_bits - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    // Two's complement to offset binary: flip the sign bit only, no clipping.
    function automatic logic [c_data_bits-1:0] to_offset_binary(input logic [c_data_bits-1:0] d);
        return d ^ 16'h8000;
    endfunction

    function automatic logic [c_frame_bits-1:0] build_frame(input logic [c_data_bits-1:0] d);
        return {6'b000000, c_pd_normal, to_offset_binary(d)};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period divider for the SPI clock: tick_o is high in the last cycle of every
// g_div-cycle window; restart_i synchronously returns the count to zero.
module spi_half_tick #(
    parameter int unsigned g_div = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [7:0] c_last = 8'(g_div - 1);

    logic [7:0] cnt;

    assign tick_o = (cnt == c_last);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (restart_i || tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pi_dac_spi_driver.sv
// Serialises PI loop corrections into SYNC_n-framed 24-bit SPI writes for the VCXO DAC,
// with a one-deep newest-wins buffer and a saturating overrun counter.
module pi_dac_spi_driver
    import pi_dac_pkg::*;
#(
    parameter int unsigned g_clk_div = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_valid_i,
    input  logic [15:0] d_i,
    input  logic        overrun_clr_i,
    output logic        dac_sclk_o,
    output logic        dac_din_o,
    output logic        dac_sync_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] overrun_cnt_o
);

    state_t                  state, state_next;
    logic [c_frame_bits-1:0] shifter, shifter_next;
    logic [4:0]              bit_cnt, bit_cnt_next;
    logic                    phase, phase_next;     // 0: SCLK low half, 1: SCLK high half
    logic [c_data_bits-1:0]  pend_data, pend_data_next;
    logic                    pend_full, pend_full_next;
    logic                    overrun_evt;
    logic                    hold_exit;
    logic                    tick;
    logic                    restart;

    // The divider restarts on every state change so each state starts a fresh half-period.
    assign restart   = (state_next != state);
    assign hold_exit = (state == HOLD) && tick;

    spi_half_tick #(
        .g_div(g_clk_div)
    ) u_half_tick (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .restart_i(restart),
        .tick_o   (tick)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        shifter_next   = shifter;
        bit_cnt_next   = bit_cnt;
        phase_next     = phase;
        pend_data_next = pend_data;
        pend_full_next = pend_full;
        overrun_evt    = 1'b0;

        if (d_valid_i && (state != IDLE) && !hold_exit) begin
            pend_data_next = d_i;
            pend_full_next = 1'b1;
            overrun_evt    = pend_full;
        end

        case (state)
            IDLE: begin
                if (d_valid_i) begin
                    shifter_next = build_frame(d_i);
                    bit_cnt_next = c_last_bit;
                    phase_next   = 1'b0;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    phase_next = 1'b0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!phase) begin
                        // Rising SCLK: present the next bit, but keep bit 0 through its high half.
                        phase_next = 1'b1;
                        if (bit_cnt != 5'd0) begin
                            shifter_next = {shifter[c_frame_bits-2:0], 1'b0};
                        end
                    end else if (bit_cnt == 5'd0) begin
                        state_next = HOLD;
                    end else begin
                        bit_cnt_next = bit_cnt - 5'd1;
                        phase_next   = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (d_valid_i) begin
                        // A fresh strobe beats a buffered value; dropping the buffer is an overrun.
                        shifter_next   = build_frame(d_i);
                        bit_cnt_next   = c_last_bit;
                        phase_next     = 1'b0;
                        pend_full_next = 1'b0;
                        overrun_evt    = pend_full;
                        state_next     = SETUP;
                    end else if (pend_full) begin
                        shifter_next   = build_frame(pend_data);
                        bit_cnt_next   = c_last_bit;
                        phase_next     = 1'b0;
                        pend_full_next = 1'b0;
                        state_next     = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            shifter   <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            pend_data <= '0;
            pend_full <= 1'b0;
        end else begin
            state     <= state_next;
            shifter   <= shifter_next;
            bit_cnt   <= bit_cnt_next;
            phase     <= phase_next;
            pend_data <= pend_data_next;
            pend_full <= pend_full_next;
        end
    end

    // Pins are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dac_sclk_o   <= 1'b1;
            dac_din_o    <= 1'b0;
            dac_sync_n_o <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            dac_sclk_o   <= !((state == SHIFT) && !phase);
            dac_din_o    <= ((state == SETUP) || (state == SHIFT)) && shifter[c_frame_bits-1];
            dac_sync_n_o <= !((state == SETUP) || (state == SHIFT));
            busy_o       <= (state != IDLE);
            done_o       <= hold_exit;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_cnt_o <= '0;
        end else if (overrun_clr_i) begin
            overrun_cnt_o <= '0;
        end else if (overrun_evt && (overrun_cnt_o != 16'hFFFF)) begin
            overrun_cnt_o <= overrun_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_pi_dac_spi_driver.sv
// Directed self-checking bench for pi_dac_spi_driver at the default divider of 4:
// a negedge monitor decodes SPI frames, and each test task compares against hand-computed values.
module tb_pi_dac_spi_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d_valid = 1'b0;
    logic [15:0] d = 16'h0000;
    logic        clr = 1'b0;
    logic        sclk, din, sync_n, busy, done;
    logic [15:0] ocnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pi_dac_spi_driver #(
        .g_clk_div(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .d_valid_i    (d_valid),
        .d_i          (d),
        .overrun_clr_i(clr),
        .dac_sclk_o   (sclk),
        .dac_din_o    (din),
        .dac_sync_n_o (sync_n),
        .busy_o       (busy),
        .done_o       (done),
        .overrun_cnt_o(ocnt)
    );

    // Frame monitor: samples DIN on each SCLK fall while SYNC_n is low; one record per done pulse.
    int          cyc = 0, start_cyc = 0, low_len = 0, nbits = 0, high_run = 0, high_before = 0;
    bit          saw_idle = 1'b1, idle_before = 1'b1, prev_sclk = 1'b1, prev_sync = 1'b1;
    logic [23:0] cur = '0;
    logic [23:0] q_frame[$];
    int          q_bits[$], q_low[$], q_rel[$], q_high[$];
    bit          q_idle[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!sync_n && prev_sync) begin
                cur         = '0;
                nbits       = 0;
                low_len     = 0;
                start_cyc   = cyc;
                high_before = high_run;
                high_run    = 0;
                idle_before = saw_idle;
                saw_idle    = 1'b0;
            end
            if (!sync_n) begin
                low_len++;
                if (prev_sclk && !sclk) begin
                    cur = {cur[22:0], din};
                    nbits++;
                end
            end else begin
                high_run++;
            end
            if (!busy) saw_idle = 1'b1;
            if (done) begin
                q_frame.push_back(cur);
                q_bits.push_back(nbits);
                q_low.push_back(low_len);
                q_rel.push_back(cyc - start_cyc + 1);
                q_high.push_back(high_before);
                q_idle.push_back(idle_before);
            end
            prev_sclk = sclk;
            prev_sync = sync_n;
        end
    end

    function automatic void clear_q();
        q_frame.delete(); q_bits.delete(); q_low.delete();
        q_rel.delete();   q_high.delete(); q_idle.delete();
    endfunction

    task automatic pulse(input logic [15:0] v, input logic c);
        @(negedge clk);
        d = v; d_valid = 1'b1; clr = c;
        @(posedge clk);
        #1;
        d_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q_frame.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (q_frame.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (sclk !== 1'b1)    begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk); end
        checks++; if (din !== 1'b0)     begin errors++; $display("FAIL reset_din: got %b want 0", din); end
        checks++; if (sync_n !== 1'b1)  begin errors++; $display("FAIL reset_sync_n: got %b want 1", sync_n); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ocnt !== 16'h0)   begin errors++; $display("FAIL reset_ocnt: got %h want 0000", ocnt); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_q();
        pulse(16'h0000, 1'b0);
        checks++; if (sync_n !== 1'b1) begin errors++; $display("FAIL latency_early_sync: got %b want 1", sync_n); end
        @(posedge clk); #1;
        checks++; if (sync_n !== 1'b0) begin errors++; $display("FAIL latency_sync: got %b want 0", sync_n); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL latency_busy: got %b want 1", busy); end
        wait_done(1, 400, ok);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no done want done"); end
        if (ok) begin
            checks++; if (q_frame[0] !== 24'h008000) begin errors++; $display("FAIL single_frame: got %h want 008000", q_frame[0]); end
            checks++; if (q_bits[0] !== 24)  begin errors++; $display("FAIL single_bits: got %0d want 24", q_bits[0]); end
            checks++; if (q_low[0] !== 196)  begin errors++; $display("FAIL single_sync_low: got %0d want 196", q_low[0]); end
            checks++; if (q_rel[0] !== 200)  begin errors++; $display("FAIL single_done_cycle: got %0d want 200", q_rel[0]); end
            checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
            checks++; if (done !== 1'b0)     begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
        end
    endtask

    task automatic test_codes();
        logic [15:0] vals [3] = '{16'h7FFF, 16'h8001, 16'h8000};
        logic [23:0] exps [3] = '{24'h00FFFF, 24'h000001, 24'h000000};
        bit ok;
        for (int i = 0; i < 3; i++) begin
            wait_idle(50, ok);
            clear_q();
            pulse(vals[i], 1'b0);
            wait_done(1, 400, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL code_timeout: got no done want done for %h", vals[i]);
            end else if (q_frame[0] !== exps[i]) begin
                errors++; $display("FAIL code_frame: got %h want %h for %h", q_frame[0], exps[i], vals[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_idle(300, ok);
        clear_q();
        pulse(16'h1357, 1'b0);
        repeat (10) @(posedge clk);
        pulse(16'h2468, 1'b0);
        pulse(16'hABCD, 1'b0);
        checks++; if (ocnt !== 16'd1) begin errors++; $display("FAIL b2b_ocnt: got %0d want 1", ocnt); end
        wait_done(2, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d frames want 2", q_frame.size()); end
        if (ok) begin
            checks++; if (q_frame[0] !== 24'h009357) begin errors++; $display("FAIL b2b_frame0: got %h want 009357", q_frame[0]); end
            checks++; if (q_frame[1] !== 24'h002BCD) begin errors++; $display("FAIL b2b_frame1: got %h want 002BCD", q_frame[1]); end
            checks++; if (q_high[1] !== 4)  begin errors++; $display("FAIL b2b_sync_gap: got %0d want 4", q_high[1]); end
            checks++; if (q_idle[1] !== 1'b0) begin errors++; $display("FAIL b2b_no_idle: got %b want 0", q_idle[1]); end
            checks++; if (q_rel[1] !== 200) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 200", q_rel[1]); end
        end
    endtask

    task automatic test_hold_exit();
        bit ok;
        wait_idle(300, ok);
        clear_q();
        pulse(16'h0F0F, 1'b0);
        repeat (20) @(posedge clk);
        pulse(16'h5555, 1'b0);
        repeat (178) @(posedge clk);
        pulse(16'hF00D, 1'b0);
        checks++; if (ocnt !== 16'd2) begin errors++; $display("FAIL hold_ocnt: got %0d want 2", ocnt); end
        wait_done(2, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: got %0d frames want 2", q_frame.size()); end
        if (ok) begin
            checks++; if (q_frame[0] !== 24'h008F0F) begin errors++; $display("FAIL hold_frame0: got %h want 008F0F", q_frame[0]); end
            checks++; if (q_frame[1] !== 24'h00700D) begin errors++; $display("FAIL hold_frame1: got %h want 00700D", q_frame[1]); end
            checks++; if (q_idle[1] !== 1'b0) begin errors++; $display("FAIL hold_no_idle: got %b want 0", q_idle[1]); end
        end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_idle_timeout: got busy want idle"); end
        checks++; if (q_frame.size() !== 2) begin errors++; $display("FAIL hold_frame_count: got %0d want 2", q_frame.size()); end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_idle(300, ok);
        pulse(16'h4321, 1'b0);
        repeat (50) @(posedge clk);
        #2;
        checks++; if (sync_n !== 1'b0) begin errors++; $display("FAIL areset_pre_sync: got %b want 0", sync_n); end
        rst = 1'b1;
        #1;
        checks++; if (sclk !== 1'b1)   begin errors++; $display("FAIL areset_sclk: got %b want 1", sclk); end
        checks++; if (din !== 1'b0)    begin errors++; $display("FAIL areset_din: got %b want 0", din); end
        checks++; if (sync_n !== 1'b1) begin errors++; $display("FAIL areset_sync_n: got %b want 1", sync_n); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (ocnt !== 16'h0)  begin errors++; $display("FAIL areset_ocnt: got %h want 0000", ocnt); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_q();
        pulse(16'h1234, 1'b0);
        wait_done(1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_timeout: got no done want done"); end
        if (ok) begin
            checks++; if (q_frame[0] !== 24'h009234) begin errors++; $display("FAIL areset_frame: got %h want 009234", q_frame[0]); end
            checks++; if (q_bits[0] !== 24) begin errors++; $display("FAIL areset_bits: got %0d want 24", q_bits[0]); end
            checks++; if (q_low[0] !== 196) begin errors++; $display("FAIL areset_sync_low: got %0d want 196", q_low[0]); end
        end
    endtask

    task automatic test_overrun_saturate();
        bit ok;
        wait_idle(300, ok);
        // Holding the strobe overruns almost every cycle; 67000 cycles exceeds 0xFFFF+3 events.
        @(negedge clk);
        d = 16'h0101; d_valid = 1'b1;
        repeat (67000) @(posedge clk);
        #1 d_valid = 1'b0;
        checks++; if (ocnt !== 16'hFFFF) begin errors++; $display("FAIL sat_count: got %h want FFFF", ocnt); end
        wait_idle(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_idle_timeout: got busy want idle"); end
        checks++; if (ocnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want FFFF", ocnt); end
        pulse(16'h1111, 1'b0);
        repeat (5) @(posedge clk);
        pulse(16'h2222, 1'b0);
        pulse(16'h3333, 1'b1);
        checks++; if (ocnt !== 16'h0) begin errors++; $display("FAIL clr_wins: got %h want 0000", ocnt); end
        pulse(16'h4444, 1'b0);
        checks++; if (ocnt !== 16'h1) begin errors++; $display("FAIL clr_resume: got %h want 0001", ocnt); end
        wait_idle(600, ok);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_codes();
        test_back_to_back();
        test_hold_exit();
        test_async_reset();
        test_overrun_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
